// File: rtl/a2_slot_pkg.sv
// Shared Apple II slot-space constants and the C8 expansion-ROM ownership state type.
package a2_slot_pkg;

    localparam logic [15:0] C8_WINDOW_LO = 16'hC800;
    localparam logic [15:0] C8_WINDOW_HI = 16'hCFFF;
    localparam logic [7:0]  CN_PAGE_LO   = 8'hC1;
    localparam logic [7:0]  CN_PAGE_HI   = 8'hC7;
    localparam logic [2:0]  INTC8_SLOT   = 3'd3;

    typedef enum logic [1:0] {
        C8_FREE,
        C8_SLOT,
        C8_INTERNAL
    } c8_state_t;

endpackage

// File: rtl/cx_addr_decode.sv
// Combinational decode of the $Cxxx slot space: Cn ROM pages, the C8 window and the release address.
module cx_addr_decode
    import a2_slot_pkg::*;
#(
    parameter logic [15:0] RELEASE_ADDR = 16'hCFFF
) (
    input  logic [15:0] addr_i,
    output logic        is_cn_page_o,
    output logic [2:0]  slot_num_o,
    output logic        is_c8_window_o,
    output logic        is_release_o
);

    always_comb begin
        is_cn_page_o   = (addr_i[15:8] >= CN_PAGE_LO) && (addr_i[15:8] <= CN_PAGE_HI);
        slot_num_o     = is_cn_page_o ? addr_i[10:8] : 3'd0;
        is_c8_window_o = (addr_i >= C8_WINDOW_LO) && (addr_i <= C8_WINDOW_HI);
        is_release_o   = (addr_i == RELEASE_ADDR);
    end

endmodule

// File: rtl/expansion_rom_arbiter.sv
// Central owner of the $C800-$CFFF expansion-ROM window: tracks the owning slot or
// the internal ROM and drives the per-slot one-hot ROM enables.
module expansion_rom_arbiter
    import a2_slot_pkg::*;
#(
    parameter bit          IIE_MODE     = 1'b1,
    parameter logic [15:0] RELEASE_ADDR = 16'hCFFF,
    parameter logic [7:0]  SLOT_MASK    = 8'hFE
) (
    input  logic        clk_logic_i,
    input  logic        reset_i,
    input  logic        bus_strobe_i,
    input  logic        phi0_i,
    input  logic [15:0] addr_i,
    input  logic        intcxrom_i,
    input  logic        slotc3rom_i,
    input  logic [7:0]  rom_present_i,
    output logic [2:0]  owner_o,
    output logic        owner_valid_o,
    output logic        intc8rom_o,
    output logic [7:0]  c8_en_o,
    output logic        internal_c8_o,
    output logic        owner_change_o
);

    localparam logic [7:0] ELIGIBLE = SLOT_MASK & 8'hFE;

    c8_state_t  state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic       change_q, change_d;

    logic       is_cn_page;
    logic [2:0] slot_num;
    logic       is_c8_window;
    logic       is_release;

    cx_addr_decode #(
        .RELEASE_ADDR (RELEASE_ADDR)
    ) u_decode (
        .addr_i         (addr_i),
        .is_cn_page_o   (is_cn_page),
        .slot_num_o     (slot_num),
        .is_c8_window_o (is_c8_window),
        .is_release_o   (is_release)
    );

    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            state_q  <= C8_FREE;
            slot_q   <= '0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            change_q <= change_d;
        end
    end

    // Priority: release address, then a Cn claim, then dropping an owner whose card vanished.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (bus_strobe_i) begin
            if (state_q == C8_SLOT && !rom_present_i[slot_q]) begin
                state_d = C8_FREE;
                slot_d  = '0;
            end
            if (is_release) begin
                state_d = C8_FREE;
                slot_d  = '0;
            end else if (is_cn_page && !intcxrom_i) begin
                if (IIE_MODE && slot_num == INTC8_SLOT && !slotc3rom_i) begin
                    state_d = C8_INTERNAL;
                    slot_d  = '0;
                end else if (ELIGIBLE[slot_num] && rom_present_i[slot_num]) begin
                    state_d = C8_SLOT;
                    slot_d  = slot_num;
                end
            end
        end
        change_d = (state_d != state_q) || (slot_d != slot_q);
    end

    always_comb begin
        c8_en_o = '0;
        if (phi0_i && is_c8_window && state_q == C8_SLOT && !intcxrom_i && rom_present_i[slot_q]) begin
            c8_en_o[slot_q] = 1'b1;
        end
        internal_c8_o  = phi0_i && is_c8_window && (intcxrom_i || state_q == C8_INTERNAL);
        owner_valid_o  = (state_q == C8_SLOT);
        owner_o        = owner_valid_o ? slot_q : 3'd0;
        intc8rom_o     = IIE_MODE && (state_q == C8_INTERNAL);
        owner_change_o = change_q;
    end

endmodule

// File: tb/tb_expansion_rom_arbiter.sv
// Directed self-checking bench for expansion_rom_arbiter; outputs are sampled on the falling edge.
module tb_expansion_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic        phi0;
    logic [15:0] addr;
    logic        intcxrom;
    logic        slotc3rom;
    logic [7:0]  present;
    logic [2:0]  owner;
    logic        owner_valid;
    logic        intc8rom;
    logic [7:0]  c8_en;
    logic        internal_c8;
    logic        owner_change;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    expansion_rom_arbiter #(
        .IIE_MODE     (1'b1),
        .RELEASE_ADDR (16'hCFFF),
        .SLOT_MASK    (8'hFE)
    ) dut (
        .clk_logic_i    (clk),
        .reset_i        (reset),
        .bus_strobe_i   (strobe),
        .phi0_i         (phi0),
        .addr_i         (addr),
        .intcxrom_i     (intcxrom),
        .slotc3rom_i    (slotc3rom),
        .rom_present_i  (present),
        .owner_o        (owner),
        .owner_valid_o  (owner_valid),
        .intc8rom_o     (intc8rom),
        .c8_en_o        (c8_en),
        .internal_c8_o  (internal_c8),
        .owner_change_o (owner_change)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe launched on a falling edge; returns on the next falling edge.
    task automatic strobe_addr(input logic [15:0] a);
        @(negedge clk);
        addr   = a;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic read_c8(input logic [15:0] a);
        addr = a;
        phi0 = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; strobe = 1'b0; phi0 = 1'b1; addr = 16'hC900;
        intcxrom = 1'b0; slotc3rom = 1'b1; present = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_owner",  {13'd0, owner}, 16'h0);
        check("rst_valid",  {15'd0, owner_valid}, 16'h0);
        check("rst_intc8",  {15'd0, intc8rom}, 16'h0);
        check("rst_c8en",   {8'd0, c8_en}, 16'h0);
        check("rst_int",    {15'd0, internal_c8}, 16'h0);
        check("rst_change", {15'd0, owner_change}, 16'h0);
        reset = 1'b0;

        // Claim slot 2
        present = 8'h04;
        strobe_addr(16'hC200);
        check("claim2_owner",  {13'd0, owner}, 16'h2);
        check("claim2_valid",  {15'd0, owner_valid}, 16'h1);
        check("claim2_change", {15'd0, owner_change}, 16'h1);
        @(negedge clk);
        check("claim2_pulse_end", {15'd0, owner_change}, 16'h0);
        read_c8(16'hC900);
        check("claim2_c8en", {8'd0, c8_en}, 16'h04);
        check("claim2_int",  {15'd0, internal_c8}, 16'h0);
        phi0 = 1'b0; #1;
        check("claim2_nophi0", {8'd0, c8_en}, 16'h00);

        // Release on $CFFF: old owner still enabled during the hit cycle
        @(negedge clk);
        addr = 16'hCFFF; strobe = 1'b1; phi0 = 1'b1; #1;
        check("rel_hit_c8en", {8'd0, c8_en}, 16'h04);
        @(negedge clk);
        strobe = 1'b0;
        check("rel_valid",  {15'd0, owner_valid}, 16'h0);
        check("rel_owner",  {13'd0, owner}, 16'h0);
        check("rel_change", {15'd0, owner_change}, 16'h1);
        read_c8(16'hC900);
        check("rel_c8en", {8'd0, c8_en}, 16'h00);

        // Internal C8 ROM via $C3xx with SLOTC3ROM off
        slotc3rom = 1'b0;
        strobe_addr(16'hC300);
        check("intc8_set",   {15'd0, intc8rom}, 16'h1);
        check("intc8_valid", {15'd0, owner_valid}, 16'h0);
        read_c8(16'hC800);
        check("intc8_int",  {15'd0, internal_c8}, 16'h1);
        check("intc8_c8en", {8'd0, c8_en}, 16'h00);
        strobe_addr(16'hCFFF);
        check("intc8_clr", {15'd0, intc8rom}, 16'h0);
        slotc3rom = 1'b1;

        // Slot 3 with SLOTC3ROM on claims as a normal slot
        present = 8'h0C;
        strobe_addr(16'hC3A0);
        check("slot3_owner", {13'd0, owner}, 16'h3);
        check("slot3_intc8", {15'd0, intc8rom}, 16'h0);

        // INTCXROM overrides enables but keeps the latched owner
        present = 8'h24;
        strobe_addr(16'hC200);
        check("own2_owner", {13'd0, owner}, 16'h2);
        intcxrom = 1'b1;
        strobe_addr(16'hC500);
        check("cx_owner",  {13'd0, owner}, 16'h2);
        check("cx_change", {15'd0, owner_change}, 16'h0);
        read_c8(16'hC800);
        check("cx_int",  {15'd0, internal_c8}, 16'h1);
        check("cx_c8en", {8'd0, c8_en}, 16'h00);
        intcxrom = 1'b0; #1;
        check("cx_restore_c8en", {8'd0, c8_en}, 16'h04);
        check("cx_restore_int",  {15'd0, internal_c8}, 16'h0);

        // Re-claim of current owner, and claim of an absent card
        strobe_addr(16'hC200);
        check("reclaim_change", {15'd0, owner_change}, 16'h0);
        check("reclaim_owner",  {13'd0, owner}, 16'h2);
        strobe_addr(16'hC600);
        check("absent6_owner",  {13'd0, owner}, 16'h2);
        check("absent6_change", {15'd0, owner_change}, 16'h0);

        // Switch ownership directly to slot 5
        strobe_addr(16'hC5FF);
        check("claim5_owner",  {13'd0, owner}, 16'h5);
        check("claim5_change", {15'd0, owner_change}, 16'h1);
        read_c8(16'hCABC);
        check("claim5_c8en", {8'd0, c8_en}, 16'h20);

        // Owner card disappears: masked at once, freed on next strobe
        strobe_addr(16'hC200);
        present = 8'h20; #1;
        read_c8(16'hC800);
        check("gone_c8en",  {8'd0, c8_en}, 16'h00);
        check("gone_owner", {13'd0, owner}, 16'h2);
        strobe_addr(16'hC080);
        check("gone_valid",  {15'd0, owner_valid}, 16'h0);
        check("gone_change", {15'd0, owner_change}, 16'h1);

        // Reset wins over a simultaneous strobe
        present = 8'h10;
        @(negedge clk);
        reset = 1'b1; strobe = 1'b1; addr = 16'hC400;
        @(negedge clk);
        strobe = 1'b0; addr = 16'hC800; phi0 = 1'b1; #1;
        check("rststb_owner",  {13'd0, owner}, 16'h0);
        check("rststb_valid",  {15'd0, owner_valid}, 16'h0);
        check("rststb_change", {15'd0, owner_change}, 16'h0);
        check("rststb_c8en",   {8'd0, c8_en}, 16'h00);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid",  {15'd0, owner_valid}, 16'h0);
        check("post_rst_change", {15'd0, owner_change}, 16'h0);
        check("post_rst_c8en",   {8'd0, c8_en}, 16'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/expansion_rom_arbiter.md
Name: expansion_rom_arbiter

Overview:
- Central owner of the shared $C800-$CFFF expansion-ROM window across all slot cards. Tracks which slot, if any, holds the window, following Apple II rules:
  - Access to $Cn00-$CnFF claims the window for slot n.
  - Any access to $CFFF releases it.
  - INTCXROM/INTC8ROM route the window to the motherboard.
- Drives per-slot one-hot ROM enables and a read-mux select. Replaces the per-card C8 flip-flops so ownership stays consistent across cards.

Parameters:
- IIE_MODE, 1, enables INTC8ROM tracking (access to $C3xx with slotc3rom_i=0 grabs the window for internal ROM).
- RELEASE_ADDR, 16'hCFFF, address whose access releases the window.
- SLOT_MASK, 8'hFE, slots eligible to own the window; bit 0 is always ignored.

Ports:
- clk_logic_i  in  1  system logic clock.
- reset_i  in  1  synchronous, active-high reset.
- bus_strobe_i  in  1  single-cycle pulse once per Apple bus cycle; addr_i is stable when it is high.
- phi0_i  in  1  Apple phi0; enables are qualified by it.
- addr_i  in  16  Apple address bus.
- intcxrom_i  in  1  internal Cx ROM selected (soft switch).
- slotc3rom_i  in  1  slot 3 ROM selected (soft switch).
- rom_present_i  in  8  bit n: the card in slot n implements a C8 ROM.
- owner_o  out  3  current owning slot, 0 when none.
- owner_valid_o  out  1  a slot owns the window.
- intc8rom_o  out  1  internal C8 ROM latched.
- c8_en_o  out  8  one-hot: slot n must drive $C800-$CFFF this cycle.
- internal_c8_o  out  1  motherboard ROM serves $C800-$CFFF this cycle.
- owner_change_o  out  1  one-cycle pulse on any ownership change.

Behaviour:
- Reset values: owner_o=0, owner_valid_o=0, intc8rom_o=0, c8_en_o=0, internal_c8_o=0, owner_change_o=0. Reset has priority over a simultaneous strobe.
- Ownership FSM states: FREE, SLOT(n), INTERNAL. Transitions are evaluated only in cycles where bus_strobe_i=1.
- From any state, access to RELEASE_ADDR -> FREE.
- From any state, access to $Cn00-$CnFF (n=1..7) with intcxrom_i=0:
  - IIE_MODE=1, n=3 and slotc3rom_i=0 -> INTERNAL.
  - Otherwise, if SLOT_MASK[n] and rom_present_i[n] -> SLOT(n).
  - Otherwise the current state is unchanged.
- Access to $Cn00-$CnFF with intcxrom_i=1: no change. Real cards never see io_select in this case.
- Claiming the slot that already owns the window: no change, and no owner_change_o pulse.
- IIE_MODE=0: INTERNAL is unreachable; intc8rom_o is held at 0.
- State update lands on the clock edge after the strobe. owner_change_o pulses in the cycle after a strobe that altered the state.
- Enables are combinational from the registered state and the current address. For the cycle that hits RELEASE_ADDR, the pre-release owner keeps its enable, so a $CFFF read returns the owner's byte.
- c8_en_o[n] = phi0_i & addr_i in $C800-$CFFF & state==SLOT(n) & !intcxrom_i.
- internal_c8_o = phi0_i & addr_i in $C800-$CFFF & (intcxrom_i | state==INTERNAL).
- c8_en_o and internal_c8_o are never both active. c8_en_o is at most one-hot.
- Mid-cycle change of intcxrom_i: the enables follow immediately; the latched state is kept. Clearing INTCXROM restores the prior owner.
- rom_present_i falling for the current owner: the enable is masked immediately. The state releases to FREE on the next strobe.

Decomposition:
- Shared package a2_slot_pkg holds:
  - C8 window bounds (16'hC800, 16'hCFFF), CN page base 8'hC1-8'hC7, INTC8 slot constant 3.
  - typedef enum c8_state_t {C8_FREE, C8_SLOT, C8_INTERNAL}.
- One natural sub-module: cx_addr_decode, combinational. Outputs: is_cn_page, slot_num[2:0], is_c8_window, is_release. Reused by the slot-card wrappers.

Test Plan:
- Reset, then strobe $C200 with rom_present_i=8'h04 -> owner_o=2, owner_valid_o=1, owner_change_o pulses once. A phi0 read of $C900 then gives c8_en_o=8'h04.
- Owner=2, strobe $CFFF with phi0=1 -> c8_en_o=8'h04 during that cycle. The next cycle gives owner_valid_o=0; a $C900 read then gives c8_en_o=0.
- IIE_MODE=1, slotc3rom_i=0, strobe $C300 -> intc8rom_o=1. A $C800 read gives internal_c8_o=1 and c8_en_o=0. A $CFFF strobe clears intc8rom_o.
- Owner=2, intcxrom_i=1, strobe $C500 -> owner stays 2, $C800 read gives internal_c8_o=1. Then intcxrom_i=0 -> c8_en_o=8'h04 again.
- Owner=2, strobe $C200 again -> no owner_change_o pulse. Strobe $C600 with rom_present_i[6]=0 -> owner stays 2.
- reset_i=1 in the same cycle as a strobe of $C400 -> all outputs 0. The state stays FREE after reset deasserts.
